mux_sel_scanner: RTL

//  Sequencer that wraps the 4-to-1 selector stage from both sides.

---
 rtl/mux_sel_scanner.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: steps the select of a 4-to-1 selector stage through every
// channel, holds each select value for DWELL cycles, samples the selector
// output at the end of each hold and publishes the assembled snapshot with a
// one-cycle valid pulse and a changed-since-last-snapshot flag.
module mux_sel_scanner #(
   parameter int NR_CH = 4,
   parameter int SEL_W = 2,
   parameter int DWELL = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cont,
   output logic [SEL_W-1:0] sel,
   input  logic             y_in,
   output logic             busy,
   output logic [NR_CH-1:0] snap,
   output logic             snap_valid,
   output logic             chg
);

   localparam int               CNT_W    = $clog2(DWELL) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NR_CH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NR_CH-1:0] shadow_q, shadow_d;
   logic [NR_CH-1:0] snap_q, snap_d;
   logic             snap_valid_q, snap_valid_d;
   logic             chg_q, chg_d;
   logic             busy_q, busy_d;

   // Next-state logic: dwell counting, channel stepping, snapshot assembly.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; otherwise synthesis infers a latch to hold the old value.
      state_d      = state_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      shadow_d     = shadow_q;
      snap_d       = snap_q;
      snap_valid_d = 1'b0;
      chg_d        = 1'b0;

      case (state_q)
         IDLE: begin
            sel_d = '0;
            cnt_d = '0;
            if (start || cont) begin
               state_d = SCAN;
            end
         end

         SCAN: begin
            if (cnt_q == CNT_LAST) begin
               // End of the hold: capture this channel and move on.
               cnt_d           = '0;
               shadow_d[sel_q] = y_in;
               if (sel_q < SEL_LAST) begin
                  sel_d = sel_q + 1'b1;
               end else begin
                  // Last channel goes straight into the snapshot, bypassing shadow.
                  state_d      = DONE;
                  snap_d       = {y_in, shadow_q[NR_CH-2:0]};
                  chg_d        = (snap_d != snap_q);
                  snap_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DONE: begin
            // Single cycle: snap_valid/chg fall back to 0 via the defaults.
            sel_d   = '0;
            cnt_d   = '0;
            state_d = cont ? SCAN : IDLE;
         end

         default: begin
            state_d = IDLE;
            sel_d   = '0;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; rst clears everything without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: shadow and snap are ordinary registers that must read 0 after
         // reset, so they sit in the reset branch like the control state.
         state_q      <= IDLE;
         sel_q        <= '0;
         cnt_q        <= '0;
         shadow_q     <= '0;
         snap_q       <= '0;
         snap_valid_q <= 1'b0;
         chg_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge
         // values, independent of statement order.
         state_q      <= state_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         snap_q       <= snap_d;
         snap_valid_q <= snap_valid_d;
         chg_q        <= chg_d;
         busy_q       <= busy_d;
      end
   end

   assign sel        = sel_q;
   assign busy       = busy_q;
   assign snap       = snap_q;
   assign snap_valid = snap_valid_q;
   assign chg        = chg_q;

endmodule
